// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver
// Purpose  : Command-side initiator for a JK flip-flop register bank.
//            Accepts masked SET / CLEAR / TOGGLE / LOAD commands over a
//            valid/ready handshake, produces one cycle of J/K excitation,
//            reads the bank back and re-drives a LOAD of the expected value
//            on mismatch, up to MAX_RETRY times, before reporting an error.
// Ports    : clk        - rising-edge clock shared with the JK bank
//            reset      - asynchronous active-high reset
//            cmd_valid  - command present
//            cmd_ready  - driver can accept a command (state == IDLE)
//            cmd_op     - 00=SET, 01=CLEAR, 10=TOGGLE, 11=LOAD
//            cmd_mask   - bits affected by the command
//            cmd_data   - LOAD target value (ignored for other ops)
//            q_fb       - current JK bank output
//            J, K       - registered excitation to the bank
//            busy       - command in progress
//            done       - one-cycle completion pulse
//            error      - one-cycle pulse with done when retries ran out
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_driver #(
  parameter int WIDTH     = 32,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_DRIVE = 2'd1;
  localparam logic [1:0] c_ST_CHECK = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  localparam logic [1:0] c_OP_SET    = 2'b00;
  localparam logic [1:0] c_OP_CLEAR  = 2'b01;
  localparam logic [1:0] c_OP_TOGGLE = 2'b10;

  localparam logic [2:0] c_MAX_RETRY = 3'(MAX_RETRY);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mask_q,  mask_d;
  logic [WIDTH-1:0] exp_q,   exp_d;
  logic [2:0]       retry_q, retry_d;
  logic [WIDTH-1:0] j_q,     j_d;
  logic [WIDTH-1:0] k_q,     k_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             error_q, error_d;

  logic             w_accept;
  logic             w_match;
  logic             w_can_retry;
  logic [WIDTH-1:0] w_exp_new;

  assign cmd_ready   = (state_q == c_ST_IDLE);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_match     = (q_fb == exp_q);
  assign w_can_retry = (retry_q < c_MAX_RETRY);

  // Expected bank contents after the command, from q sampled at accept.
  always_comb begin
    w_exp_new = q_fb;
    case (cmd_op)
      c_OP_SET:    w_exp_new = q_fb | cmd_mask;
      c_OP_CLEAR:  w_exp_new = q_fb & ~cmd_mask;
      c_OP_TOGGLE: w_exp_new = q_fb ^ cmd_mask;
      default:     w_exp_new = (q_fb & ~cmd_mask) | (cmd_data & cmd_mask);
    endcase
  end

  // State register (and all datapath registers).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_ST_IDLE;
      mask_q  <= '0;
      exp_q   <= '0;
      retry_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      exp_q   <= exp_d;
      retry_q <= retry_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:  if (w_accept) state_d = c_ST_DRIVE;
      c_ST_DRIVE: state_d = c_ST_CHECK;
      c_ST_CHECK: begin
        if (!w_match && w_can_retry) state_d = c_ST_DRIVE;
        else                         state_d = c_ST_RESP;
      end
      default:    state_d = c_ST_IDLE;
    endcase
  end

  // Output / datapath next values. Outputs are registered, so each value is
  // computed one edge early: J/K are loaded on the edge entering DRIVE and
  // cleared on the edge leaving it, which keeps them zero in every other
  // state. done/error are loaded on the edge entering RESP.
  always_comb begin
    mask_d  = mask_q;
    exp_d   = exp_q;
    retry_d = retry_q;
    j_d     = '0;
    k_d     = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (w_accept) begin
          mask_d = cmd_mask;
          exp_d  = w_exp_new;
          busy_d = 1'b1;
          case (cmd_op)
            c_OP_SET:    j_d = cmd_mask;
            c_OP_CLEAR:  k_d = cmd_mask;
            c_OP_TOGGLE: begin
              j_d = cmd_mask;
              k_d = cmd_mask;
            end
            default: begin
              j_d = w_exp_new & cmd_mask;
              k_d = ~w_exp_new & cmd_mask;
            end
          endcase
        end
      end
      c_ST_DRIVE: busy_d = 1'b1;
      c_ST_CHECK: begin
        if (w_match) begin
          done_d = 1'b1;
        end else if (w_can_retry) begin
          // Retries always force the expected value; a TOGGLE is never
          // re-toggled because that would compound the error.
          retry_d = retry_q + 3'd1;
          busy_d  = 1'b1;
          j_d     = exp_q & mask_q;
          k_d     = ~exp_q & mask_q;
        end else begin
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end
      default: retry_d = '0;
    endcase
  end

  assign J     = j_q;
  assign K     = k_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_driver
// Purpose  : Directed self-checking bench for jk_bank_driver. Each test task
//            drives a command, plays the role of the JK bank on q_fb, and
//            compares {J, K, busy, done, error, cmd_ready} every cycle
//            against a hand-computed table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_driver;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_mask;
  logic [31:0] cmd_data;
  logic [31:0] q_fb;
  logic [31:0] J;
  logic [31:0] K;
  logic        busy;
  logic        done;
  logic        error;

  int n_assert = 0;
  int n_fail   = 0;

  wire [67:0] obs = {J, K, busy, done, error, cmd_ready};

  jk_bank_driver #(.WIDTH(32), .MAX_RETRY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_data  (cmd_data),
    .q_fb      (q_fb),
    .J         (J),
    .K         (K),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected-word layout: {J, K, busy, done, error, cmd_ready}
  localparam logic [3:0] DRV  = 4'b1000;
  localparam logic [3:0] DONE = 4'b0100;
  localparam logic [3:0] ERR  = 4'b0110;
  localparam logic [3:0] IDL  = 4'b0001;

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_mask = '0; cmd_data = '0; q_fb = '0;
    @(negedge clk);
    n_assert++;
    if (obs !== {64'h0, IDL}) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, {64'h0, IDL});
    end
    reset = 1'b0;
    @(negedge clk);
    n_assert++;
    if (obs !== {64'h0, IDL}) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", obs, {64'h0, IDL});
    end
  endtask

  task automatic test_set();
    logic [67:0] ev [1:4];
    ev[1] = {32'h0000_00FF, 32'h0, DRV};
    ev[2] = {64'h0, DRV};
    ev[3] = {64'h0, DONE};
    ev[4] = {64'h0, IDL};
    q_fb = 32'h0; cmd_valid = 1'b1; cmd_op = 2'b00;
    cmd_mask = 32'h0000_00FF; cmd_data = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_assert++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL set cycle %0d: got %h expected %h", i, obs, ev[i]);
      end
      if (i == 1) begin
        cmd_valid = 1'b0;
        q_fb = 32'h0000_00FF;
      end
    end
  endtask

  task automatic test_load();
    logic [67:0] ev [1:4];
    ev[1] = {32'h1234_5678, 32'hEDCB_A987, DRV};
    ev[2] = {64'h0, DRV};
    ev[3] = {64'h0, DONE};
    ev[4] = {64'h0, IDL};
    q_fb = 32'hFFFF_0000; cmd_valid = 1'b1; cmd_op = 2'b11;
    cmd_mask = 32'hFFFF_FFFF; cmd_data = 32'h1234_5678;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_assert++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL load cycle %0d: got %h expected %h", i, obs, ev[i]);
      end
      if (i == 1) begin
        cmd_valid = 1'b0;
        q_fb = 32'h1234_5678;
      end
    end
  endtask

  task automatic test_toggle_retry();
    logic [67:0] ev [1:6];
    ev[1] = {32'h0000_FFFF, 32'h0000_FFFF, DRV};
    ev[2] = {64'h0, DRV};
    ev[3] = {32'h0000_5555, 32'h0000_AAAA, DRV};
    ev[4] = {64'h0, DRV};
    ev[5] = {64'h0, DONE};
    ev[6] = {64'h0, IDL};
    q_fb = 32'hAAAA_AAAA; cmd_valid = 1'b1; cmd_op = 2'b10;
    cmd_mask = 32'h0000_FFFF; cmd_data = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_assert++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL toggle_retry cycle %0d: got %h expected %h", i, obs, ev[i]);
      end
      if (i == 1) cmd_valid = 1'b0;
      if (i == 3) q_fb = 32'hAAAA_5555;
    end
  endtask

  task automatic test_retry_exhaust();
    logic [67:0] ev [1:8];
    ev[1] = {32'h1, 32'h0, DRV};
    ev[2] = {64'h0, DRV};
    ev[3] = {32'h1, 32'h0, DRV};
    ev[4] = {64'h0, DRV};
    ev[5] = {32'h1, 32'h0, DRV};
    ev[6] = {64'h0, DRV};
    ev[7] = {64'h0, ERR};
    ev[8] = {64'h0, IDL};
    q_fb = 32'h0; cmd_valid = 1'b1; cmd_op = 2'b00;
    cmd_mask = 32'h1; cmd_data = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_assert++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL retry_exhaust cycle %0d: got %h expected %h", i, obs, ev[i]);
      end
      if (i == 1) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_command();
    logic [67:0] ev [1:4];
    q_fb = 32'h0000_00FF; cmd_valid = 1'b1; cmd_op = 2'b01;
    cmd_mask = 32'h0000_00F0; cmd_data = 32'h0;
    @(negedge clk);
    n_assert++;
    if (obs !== {32'h0, 32'h0000_00F0, DRV}) begin
      n_fail++;
      $display("FAIL clear_drive: got %h expected %h", obs, {32'h0, 32'h0000_00F0, DRV});
    end
    cmd_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_assert++;
    if (obs !== {64'h0, IDL}) begin
      n_fail++;
      $display("FAIL async_abort: got %h expected %h", obs, {64'h0, IDL});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_assert++;
      if (obs !== {64'h0, IDL}) begin
        n_fail++;
        $display("FAIL abort_no_done cycle %0d: got %h expected %h", i, obs, {64'h0, IDL});
      end
    end
    // Follow-up SET of bits already set: exp = 0xFF, bank unchanged.
    ev[1] = {32'h0000_000F, 32'h0, DRV};
    ev[2] = {64'h0, DRV};
    ev[3] = {64'h0, DONE};
    ev[4] = {64'h0, IDL};
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_mask = 32'h0000_000F;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_assert++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL set_after_abort cycle %0d: got %h expected %h", i, obs, ev[i]);
      end
      if (i == 1) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [67:0] ev [1:8];
    ev[1] = {64'h0, DRV};
    ev[2] = {64'h0, DRV};
    ev[3] = {64'h0, DONE};
    ev[4] = {64'h0, IDL};
    ev[5] = {32'h3, 32'h3, DRV};
    ev[6] = {64'h0, DRV};
    ev[7] = {64'h0, DONE};
    ev[8] = {64'h0, IDL};
    // First command: SET with mask 0, trivially passes (exp = q = 5).
    q_fb = 32'h5; cmd_valid = 1'b1; cmd_op = 2'b00;
    cmd_mask = 32'h0; cmd_data = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_assert++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, ev[i]);
      end
      // Second command presented immediately, valid held high while busy:
      // TOGGLE mask 3 on q = 5 gives exp = 6.
      if (i == 1) begin
        cmd_op = 2'b10;
        cmd_mask = 32'h3;
      end
      if (i == 5) begin
        cmd_valid = 1'b0;
        q_fb = 32'h6;
      end
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_load();
    test_toggle_retry();
    test_retry_exhaust();
    test_reset_mid_command();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Command-side initiator for a 32-bit JK register bank (JK flip-flop array with async active-high reset).
- Accepts masked SET/CLEAR/TOGGLE/LOAD commands over a valid/ready handshake and generates one cycle of J/K excitation.
- Reads the bank output back and checks it against the expected value, retrying with a LOAD of the expected value on mismatch.
- Sits between a control/CSR master and the JK bank, so callers never hand-compute excitation.

Parameters:
- WIDTH, 32: data width of the bank, mask, J, K and feedback.
- MAX_RETRY, 2: number of re-drives after a failed check before error is flagged (0..7).

Ports:
- clk  input  1  rising-edge clock shared with the JK bank
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  driver can accept a command
- cmd_op  input  2  00=SET, 01=CLEAR, 10=TOGGLE, 11=LOAD
- cmd_mask  input  WIDTH  bits affected by the command
- cmd_data  input  WIDTH  target value for LOAD; ignored otherwise
- q_fb  input  WIDTH  current JK bank output q
- J  output  WIDTH  J excitation to bank
- K  output  WIDTH  K excitation to bank
- busy  output  1  command in progress
- done  output  1  one-cycle pulse: command finished
- error  output  1  one-cycle pulse coincident with done: retries exhausted

Behaviour:
- Reset (async, any state):
  - State = IDLE.
  - J = K = 0, busy = 0, done = 0, error = 0, retry count = 0.
  - cmd_ready = 1 after reset deasserts.
- All outputs are registered except cmd_ready, which equals (state == IDLE).
- J and K are 0 in every state except DRIVE, so the bank holds its value.
- IDLE:
  - On cmd_valid && cmd_ready, capture mask and op, and compute exp from q_fb sampled at the same edge:
    - SET: exp = q | mask
    - CLEAR: exp = q & ~mask
    - TOGGLE: exp = q ^ mask
    - LOAD: exp = (q & ~mask) | (data & mask)
  - Go to DRIVE; busy = 1.
- DRIVE (exactly one cycle):
  - SET: J = mask, K = 0.
  - CLEAR: J = 0, K = mask.
  - TOGGLE: J = K = mask.
  - LOAD and all retries: J = exp & mask, K = ~exp & mask.
  - Unmasked bits always have J = K = 0.
  - Go to CHECK.
- CHECK (one cycle; bank has updated on the DRIVE-ending edge):
  - If q_fb == exp: go to RESP.
  - Else if retry count < MAX_RETRY: increment retry count and go to DRIVE using the LOAD excitation of exp. TOGGLE is never re-toggled.
  - Else: set the error flag and go to RESP.
- RESP (one cycle):
  - done = 1; error = flag; busy = 0.
  - Clear retry count and error flag; go to IDLE.
- Latency with no retries: accept edge T0; DRIVE in cycle 1; CHECK in cycle 2; done high in cycle 3; cmd_ready high again in cycle 4. Each retry adds 2 cycles.
- cmd_valid while busy is ignored (cmd_ready = 0). The master must hold the command until accepted.
- Mask = 0: J = K = 0, the check passes trivially, done without error.
- q_fb may change for unmasked bits during a command. The mismatch check still compares all WIDTH bits, so external disturbance produces retries and possibly error.
- Reset mid-command aborts it:
  - No done pulse.
  - J/K drop to 0 immediately (asynchronously).

Test Plan:
- Reset with q_fb = 0; SET mask = 0x0000_00FF -> J = 0x0000_00FF, K = 0 for exactly 1 cycle; q_fb = 0x0000_00FF in CHECK -> done pulse in cycle 3, error = 0.
- q_fb = 0xFFFF_0000; LOAD data = 0x1234_5678, mask = 0xFFFF_FFFF -> J = 0x1234_5678, K = 0xEDCB_A987; q_fb = 0x1234_5678 -> done, no error.
- q_fb = 0xAAAA_AAAA; TOGGLE mask = 0x0000_FFFF -> J = K = 0x0000_FFFF; exp = 0xAAAA_5555.
  - Bench returns 0xAAAA_AAAA once, then corrects it.
  - Required: retry drives J = 0x0000_5555, K = 0x0000_AAAA; done after 5 cycles, error = 0.
- Bench holds q_fb stuck at 0; SET mask = 0x1 with MAX_RETRY = 2 -> three DRIVE cycles; done and error pulse together in cycle 7; cmd_ready high in cycle 8.
- Assert reset during DRIVE of a CLEAR (mask = 0xF0) -> J/K = 0 at once, no done, cmd_ready = 1 after release; the next SET completes normally.
- cmd_valid held high across back-to-back commands -> second accepted only when cmd_ready = 1; exactly one done per command; mask = 0 command -> done in cycle 3, J = K = 0 throughout.
